store_buffer: RTL and testbench



---
 rtl/mips_core_pkg.sv | 22 ++
 rtl/store_buffer_if.sv | 35 +++
 rtl/store_buffer_fwd.sv | 49 ++++
 rtl/store_buffer.sv | 123 ++++++++++++
 tb/tb_store_buffer.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_core_pkg.sv
// mips_core_pkg: shared widths, store-buffer depth, the buffered store entry
// type and the drain FSM state encoding.
// No ports; imported by the store buffer, its interface and the forwarding
// search.
package mips_core_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int SB_DEPTH   = 8;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } sb_entry_t;

    typedef enum logic {
        SB_IDLE,
        SB_BUSY
    } sb_state_e;

endpackage

// File: rtl/store_buffer_if.sv
// store_buffer_if: groups the store-buffer channels.
//   store in : st_valid/st_addr/st_data -> st_ready
//   d_cache  : dc_valid/dc_addr/dc_data <- dc_ready
//   forward  : ld_valid/ld_addr         -> fwd_hit/fwd_data
// Modport slave is the store buffer; modport master is its environment
// (reorder buffer, d_cache and load unit).
interface store_buffer_if;
    import mips_core_pkg::*;

    logic                  st_valid;
    logic [ADDR_WIDTH-1:0] st_addr;
    logic [DATA_WIDTH-1:0] st_data;
    logic                  st_ready;

    logic                  dc_valid;
    logic [ADDR_WIDTH-1:0] dc_addr;
    logic [DATA_WIDTH-1:0] dc_data;
    logic                  dc_ready;

    logic                  ld_valid;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_data;

    modport slave (
        input  st_valid, st_addr, st_data, dc_ready, ld_valid, ld_addr,
        output st_ready, dc_valid, dc_addr, dc_data, fwd_hit, fwd_data
    );

    modport master (
        output st_valid, st_addr, st_data, dc_ready, ld_valid, ld_addr,
        input  st_ready, dc_valid, dc_addr, dc_data, fwd_hit, fwd_data
    );

endinterface

// File: rtl/store_buffer_fwd.sv
// store_buffer_fwd: combinational youngest-match search for store-to-load
// forwarding.
//   entries  : all buffer slots (valid/addr/data)
//   head     : slot of the oldest entry
//   tail     : slot the next store will be written to
//   ld_valid : lookup request; ld_addr : load byte address (word compare)
//   hit/data : a valid entry matched; data of the youngest such entry
module store_buffer_fwd
    import mips_core_pkg::*;
#(
    parameter int SB_DEPTH = mips_core_pkg::SB_DEPTH
) (
    input  sb_entry_t                     entries [SB_DEPTH],
    input  logic [$clog2(SB_DEPTH)-1:0]   head,
    input  logic [$clog2(SB_DEPTH)-1:0]   tail,
    input  logic                          ld_valid,
    input  logic [ADDR_WIDTH-1:0]         ld_addr,
    output logic                          hit,
    output logic [DATA_WIDTH-1:0]         data
);

    localparam int PTR_W = $clog2(SB_DEPTH);
    typedef logic [PTR_W-1:0] ptr_t;

    ptr_t idx;
    logic done;

    // Walk from the youngest slot (tail-1) back towards head; the first
    // valid word-address match is the youngest and wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        done = 1'b0;
        idx  = '0;
        for (int unsigned k = 0; k < SB_DEPTH; k++) begin
            idx = ptr_t'(tail - ptr_t'(k) - ptr_t'(1));
            if (!done && ld_valid && entries[idx].valid &&
                (((entries[idx].addr ^ ld_addr) >> 2) == '0)) begin
                hit  = 1'b1;
                data = entries[idx].data;
                done = 1'b1;
            end
            if (idx == head) begin
                done = 1'b1;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: circular FIFO of committed stores draining to the d_cache,
// with combinational store-to-load forwarding.
//   clk   : core clock
//   rst   : synchronous active-high reset
//   sb    : store_buffer_if.slave (store in, d_cache write out, forwarding)
//   empty : no entries buffered
//   count : current occupancy
module store_buffer
    import mips_core_pkg::*;
#(
    parameter int SB_DEPTH = mips_core_pkg::SB_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    store_buffer_if.slave               sb,
    output logic                        empty,
    output logic [$clog2(SB_DEPTH):0]   count
);

    localparam int PTR_W = $clog2(SB_DEPTH);
    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   cnt_t;
    localparam cnt_t FULL_CNT = cnt_t'(SB_DEPTH);

    sb_state_e             state_q, state_d;
    ptr_t                  head_q, tail_q;
    cnt_t                  count_q;
    logic [SB_DEPTH-1:0]   valid_q;
    logic [ADDR_WIDTH-1:0] addr_q [SB_DEPTH];
    logic [DATA_WIDTH-1:0] data_q [SB_DEPTH];
    sb_entry_t             entries [SB_DEPTH];

    logic st_ready;
    logic dc_valid;
    logic enq;
    logic deq;

    // st_ready depends only on registered occupancy, never on dc_ready.
    assign st_ready = (count_q < FULL_CNT);
    assign enq      = sb.st_valid && st_ready;
    assign deq      = dc_valid && sb.dc_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SB_IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            // enq and deq never target the same slot: enq needs a free slot,
            // and tail==head with entries present only happens when full.
            if (enq) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + ptr_t'(1);
            end
            if (deq) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + ptr_t'(1);
            end
            case ({enq, deq})
                2'b10:   count_q <= count_q + cnt_t'(1);
                2'b01:   count_q <= count_q - cnt_t'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail_q] <= sb.st_addr;
            data_q[tail_q] <= sb.st_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        dc_valid = 1'b0;
        case (state_q)
            SB_IDLE: begin
                if (enq) begin
                    state_d = SB_BUSY;
                end
            end
            SB_BUSY: begin
                dc_valid = 1'b1;
                if (deq && (count_q == cnt_t'(1)) && !enq) begin
                    state_d = SB_IDLE;
                end
            end
            default: state_d = SB_IDLE;
        endcase
    end

    always_comb begin
        for (int unsigned i = 0; i < SB_DEPTH; i++) begin
            entries[i].valid = valid_q[i];
            entries[i].addr  = addr_q[i];
            entries[i].data  = data_q[i];
        end
    end

    store_buffer_fwd #(
        .SB_DEPTH (SB_DEPTH)
    ) u_fwd (
        .entries  (entries),
        .head     (head_q),
        .tail     (tail_q),
        .ld_valid (sb.ld_valid),
        .ld_addr  (sb.ld_addr),
        .hit      (sb.fwd_hit),
        .data     (sb.fwd_data)
    );

    assign sb.st_ready = st_ready;
    assign sb.dc_valid = dc_valid;
    assign sb.dc_addr  = addr_q[head_q];
    assign sb.dc_data  = data_q[head_q];
    assign empty       = (count_q == '0);
    assign count       = count_q;

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: store_buffer bench with a queue-based reference model,
// directed scenarios with literal expectations and a randomized phase.
module tb_store_buffer;

    localparam int DEPTH = 8;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       empty;
    logic [3:0] count;

    int checks   = 0;
    int failures = 0;

    ent_t q[$];
    bit   model_live = 1'b0;
    bit   m_enq, m_deq;

    store_buffer_if sbif ();

    store_buffer #(
        .SB_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .sb    (sbif.slave),
        .empty (empty),
        .count (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: occupancy queue updated with the rules of the FIFO.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            q.delete();
            model_live = 1'b1;
        end else if (model_live) begin
            m_enq = sbif.st_valid && (q.size() < DEPTH);
            m_deq = (q.size() != 0) && sbif.dc_ready;
            if (m_deq) void'(q.pop_front());
            if (m_enq) q.push_back('{a: sbif.st_addr, d: sbif.st_data});
        end
    end

    // Compare process: every negedge once the model has seen a reset.
    initial forever begin
        bit          e_hit;
        logic [31:0] e_data;
        @(negedge clk);
        if (model_live) begin
            chk("st_ready", sbif.st_ready, q.size() < DEPTH);
            chk("dc_valid", sbif.dc_valid, q.size() != 0);
            chk("empty", empty, q.size() == 0);
            chk("count", count, q.size());
            if (q.size() != 0) begin
                chk("dc_addr", sbif.dc_addr, q[0].a);
                chk("dc_data", sbif.dc_data, q[0].d);
            end
            e_hit  = 1'b0;
            e_data = '0;
            if (sbif.ld_valid) begin
                for (int i = q.size() - 1; i >= 0; i--) begin
                    if (!e_hit && (q[i].a[31:2] == sbif.ld_addr[31:2])) begin
                        e_hit  = 1'b1;
                        e_data = q[i].d;
                    end
                end
            end
            chk("fwd_hit", sbif.fwd_hit, e_hit);
            if (e_hit) chk("fwd_data", sbif.fwd_data, e_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        sbif.st_valid = 1'b0;
        sbif.st_addr  = '0;
        sbif.st_data  = '0;
        sbif.dc_ready = 1'b0;
        sbif.ld_valid = 1'b0;
        sbif.ld_addr  = '0;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        sbif.st_valid = 1'b1;
        sbif.st_addr  = a;
        sbif.st_data  = d;
        step();
        sbif.st_valid = 1'b0;
    endtask

    task automatic drain();
        sbif.st_valid = 1'b0;
        sbif.dc_ready = 1'b1;
        for (int i = 0; i < 2 * DEPTH && !empty; i++) step();
        chk("drain_empty", empty, 1'b1);
        sbif.dc_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        sbif.ld_valid = 1'b1;
        sbif.ld_addr  = 32'h100;
        step();
        step();
        chk("rst_st_ready", sbif.st_ready, 1'b1);
        chk("rst_dc_valid", sbif.dc_valid, 1'b0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_count", count, 4'd0);
        chk("rst_fwd_hit", sbif.fwd_hit, 1'b0);
        rst = 1'b0;
        sbif.ld_valid = 1'b0;
        step();

        // Single store: one-cycle latency to the d_cache, then empty.
        push(32'h100, 32'hAAAA_0001);
        chk("lat_dc_valid", sbif.dc_valid, 1'b1);
        chk("lat_dc_addr", sbif.dc_addr, 32'h100);
        chk("lat_dc_data", sbif.dc_data, 32'hAAAA_0001);
        chk("lat_count", count, 4'd1);
        sbif.dc_ready = 1'b1;
        step();
        sbif.dc_ready = 1'b0;
        chk("lat_empty", empty, 1'b1);
        chk("lat_dc_valid_off", sbif.dc_valid, 1'b0);

        // Fill to full, extra store ignored, dequeue alongside a store.
        for (int i = 0; i < DEPTH; i++) push(32'h300 + 4 * i, 32'h3000 + i);
        chk("full_st_ready", sbif.st_ready, 1'b0);
        chk("full_count", count, 4'd8);
        push(32'h400, 32'h99);
        chk("full_ignored_count", count, 4'd8);
        sbif.st_valid = 1'b1;
        sbif.st_addr  = 32'h400;
        sbif.st_data  = 32'h99;
        sbif.dc_ready = 1'b1;
        #1;
        chk("full_deq_head", sbif.dc_addr, 32'h300);
        step();
        sbif.st_valid = 1'b0;
        sbif.dc_ready = 1'b0;
        sbif.ld_valid = 1'b1;
        sbif.ld_addr  = 32'h400;
        #1;
        chk("full_deq_count", count, 4'd7);
        chk("full_deq_next_head", sbif.dc_addr, 32'h304);
        chk("full_ninth_not_taken", sbif.fwd_hit, 1'b0);
        sbif.ld_valid = 1'b0;
        drain();

        // Youngest match wins on forwarding.
        push(32'h200, 32'h11);
        push(32'h204, 32'h22);
        push(32'h200, 32'h33);
        sbif.ld_valid = 1'b1;
        sbif.ld_addr  = 32'h202;
        #1;
        chk("fwd_young_hit", sbif.fwd_hit, 1'b1);
        chk("fwd_young_data", sbif.fwd_data, 32'h33);
        sbif.ld_addr = 32'h208;
        #1;
        chk("fwd_miss", sbif.fwd_hit, 1'b0);
        sbif.ld_addr  = 32'h204;
        sbif.dc_ready = 1'b1;
        #1;
        chk("fwd_mid_data", sbif.fwd_data, 32'h22);
        sbif.ld_valid = 1'b0;
        #1;
        chk("fwd_ld_invalid", sbif.fwd_hit, 1'b0);
        drain();

        // Steady enqueue+dequeue across pointer wrap.
        for (int i = 0; i < 4; i++) push(32'h500 + 4 * i, 32'h5000 + i);
        for (int k = 0; k < 20; k++) begin
            sbif.st_valid = 1'b1;
            sbif.st_addr  = 32'h500 + 4 * (k + 4);
            sbif.st_data  = 32'h5000 + k + 4;
            sbif.dc_ready = 1'b1;
            #1;
            chk("wrap_order", sbif.dc_addr, 32'h500 + 4 * k);
            step();
            chk("wrap_count", count, 4'd4);
        end
        drain();

        // Head stable while the d_cache stalls, then reset mid-drain.
        for (int i = 0; i < 5; i++) push(32'h700 + 4 * i, 32'h7000 + i);
        sbif.ld_valid = 1'b0;
        sbif.ld_addr  = 32'h700;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("stall_addr", sbif.dc_addr, 32'h700);
            chk("stall_data", sbif.dc_data, 32'h7000);
            chk("stall_no_fwd", sbif.fwd_hit, 1'b0);
        end
        rst = 1'b1;
        sbif.dc_ready = 1'b1;
        step();
        rst = 1'b0;
        sbif.dc_ready = 1'b0;
        chk("midrst_count", count, 4'd0);
        chk("midrst_dc_valid", sbif.dc_valid, 1'b0);
        chk("midrst_st_ready", sbif.st_ready, 1'b1);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst           = ($urandom % 250) == 0;
            sbif.st_valid = $urandom % 2;
            sbif.st_addr  = 32'h600 + 4 * ($urandom % 8);
            sbif.st_data  = $urandom;
            sbif.dc_ready = ($urandom % 3) == 0;
            sbif.ld_valid = $urandom % 2;
            sbif.ld_addr  = 32'h600 + 4 * ($urandom % 9) + ($urandom % 4);
            step();
        end
        rst = 1'b0;
        idle_inputs();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
